// File: rtl/timer_1us_tick.sv
// Periodic tick generator: divides clk_36MHz into a 1 us time base and
// emits a one-cycle pulse on q every PERIOD_US microseconds.
module timer_1us_tick #(
  parameter int unsigned PERIOD_US     = 1000,
  parameter int unsigned CYCLES_PER_US = 36
) (
  input  logic clk_36MHz,
  input  logic reset,
  input  logic en,
  output logic q
);

  // Zero-valued parameters degrade to 1 so the counters always have a terminal value.
  localparam int unsigned PERIOD_EFF = (PERIOD_US == 0) ? 1 : PERIOD_US;
  localparam int unsigned CYCLES_EFF = (CYCLES_PER_US == 0) ? 1 : CYCLES_PER_US;
  localparam int PRE_W = (CYCLES_EFF > 1) ? $clog2(CYCLES_EFF) : 1;
  localparam int US_W  = (PERIOD_EFF > 1) ? $clog2(PERIOD_EFF) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CYCLES_EFF - 1);
  localparam logic [US_W-1:0]  US_LAST  = US_W'(PERIOD_EFF - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [US_W-1:0]  us_q, us_d;
  logic             tick_q, tick_d;

  always_comb begin
    pre_d  = pre_q;
    us_d   = us_q;
    tick_d = 1'b0;
    if (en) begin
      if (pre_q == PRE_LAST) begin
        pre_d = '0;
        if (us_q == US_LAST) begin
          us_d   = '0;
          tick_d = 1'b1;
        end else begin
          us_d = us_q + US_W'(1);
        end
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end
  end

  always_ff @(posedge clk_36MHz) begin
    if (!reset) begin
      pre_q  <= '0;
      us_q   <= '0;
      tick_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      us_q   <= us_d;
      tick_q <= tick_d;
    end
  end

  assign q = tick_q;

endmodule

// File: tb/tb_timer_1us_tick.sv
// Directed bench for timer_1us_tick: several parameterisations share one
// clock, reset and enable; each scenario task checks its own expectations.
module tb_timer_1us_tick;

  logic clk_36MHz;
  logic reset;
  logic en;
  logic qA, qB, qC, qD;

  int checks;
  int fails;

  timer_1us_tick #(.PERIOD_US(3), .CYCLES_PER_US(36)) dutA (
    .clk_36MHz(clk_36MHz), .reset(reset), .en(en), .q(qA));
  timer_1us_tick #(.PERIOD_US(1), .CYCLES_PER_US(1)) dutB (
    .clk_36MHz(clk_36MHz), .reset(reset), .en(en), .q(qB));
  timer_1us_tick #(.PERIOD_US(1024), .CYCLES_PER_US(2)) dutC (
    .clk_36MHz(clk_36MHz), .reset(reset), .en(en), .q(qC));
  timer_1us_tick #(.PERIOD_US(0), .CYCLES_PER_US(4)) dutD (
    .clk_36MHz(clk_36MHz), .reset(reset), .en(en), .q(qD));

  initial clk_36MHz = 1'b0;
  always #5 clk_36MHz = ~clk_36MHz;

  // Advance one rising edge and settle past it before sampling.
  task automatic step();
    @(posedge clk_36MHz);
    #1;
  endtask

  task automatic applyReset();
    reset = 1'b0;
    en    = 1'b1;
    repeat (2) step();
    reset = 1'b1;
    en    = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    en    = 1'b1;
    repeat (2) step();
    checks++;
    if (qA !== 1'b0) begin fails++; $display("[TB] FAIL reset_qA: q=%b expected 0", qA); end
    checks++;
    if (qB !== 1'b0) begin fails++; $display("[TB] FAIL reset_qB: q=%b expected 0", qB); end
    checks++;
    if (qC !== 1'b0) begin fails++; $display("[TB] FAIL reset_qC: q=%b expected 0", qC); end
    checks++;
    if (qD !== 1'b0) begin fails++; $display("[TB] FAIL reset_qD: q=%b expected 0", qD); end
  endtask

  task automatic test_periodic();
    logic exp;
    applyReset();
    for (int n = 1; n <= 545; n++) begin
      step();
      exp = (n % 108 == 0);
      checks++;
      if (qA !== exp) begin
        fails++;
        $display("[TB] FAIL periodic cycle %0d: q=%b expected %b", n, qA, exp);
      end
    end
  endtask

  task automatic test_enable_gap();
    logic exp;
    applyReset();
    for (int n = 1; n <= 270; n++) begin
      en = !(n >= 41 && n <= 90);
      step();
      exp = (n == 158 || n == 266);
      checks++;
      if (qA !== exp) begin
        fails++;
        $display("[TB] FAIL enable_gap cycle %0d: q=%b expected %b", n, qA, exp);
      end
    end
    en = 1'b1;
  endtask

  task automatic test_mid_reset();
    logic exp;
    applyReset();
    for (int n = 1; n <= 320; n++) begin
      reset = (n == 100) ? 1'b0 : 1'b1;
      step();
      exp = (n == 208 || n == 316);
      checks++;
      if (qA !== exp) begin
        fails++;
        $display("[TB] FAIL mid_reset cycle %0d: q=%b expected %b", n, qA, exp);
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_reset_at_terminal();
    logic exp;
    applyReset();
    for (int n = 1; n <= 220; n++) begin
      reset = (n == 108) ? 1'b0 : 1'b1;
      step();
      exp = (n == 216);
      checks++;
      if (qA !== exp) begin
        fails++;
        $display("[TB] FAIL reset_at_terminal cycle %0d: q=%b expected %b", n, qA, exp);
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_terminal_en_drop();
    logic exp;
    applyReset();
    for (int n = 1; n <= 330; n++) begin
      en = (n == 108) ? 1'b0 : 1'b1;
      step();
      exp = (n == 109 || n == 217 || n == 325);
      checks++;
      if (qA !== exp) begin
        fails++;
        $display("[TB] FAIL terminal_en_drop cycle %0d: q=%b expected %b", n, qA, exp);
      end
    end
    en = 1'b1;
  endtask

  task automatic test_boundary_1x1();
    logic exp;
    applyReset();
    for (int n = 1; n <= 16; n++) begin
      en    = !(n >= 6 && n <= 8);
      reset = !(n >= 12 && n <= 13);
      step();
      exp = en && reset;
      checks++;
      if (qB !== exp) begin
        fails++;
        $display("[TB] FAIL boundary_1x1 cycle %0d: q=%b expected %b", n, qB, exp);
      end
    end
    en    = 1'b1;
    reset = 1'b1;
  endtask

  task automatic test_zero_period();
    logic exp;
    applyReset();
    for (int n = 1; n <= 20; n++) begin
      step();
      exp = (n % 4 == 0);
      checks++;
      if (qD !== exp) begin
        fails++;
        $display("[TB] FAIL zero_period cycle %0d: q=%b expected %b", n, qD, exp);
      end
    end
  endtask

  task automatic test_wide_period();
    logic exp;
    applyReset();
    for (int n = 1; n <= 4100; n++) begin
      step();
      exp = (n == 2048 || n == 4096);
      checks++;
      if (qC !== exp) begin
        fails++;
        $display("[TB] FAIL wide_period cycle %0d: q=%b expected %b", n, qC, exp);
      end
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    reset  = 1'b0;
    en     = 1'b0;
    test_reset();
    test_periodic();
    test_enable_gap();
    test_mid_reset();
    test_reset_at_terminal();
    test_terminal_en_drop();
    test_boundary_1x1();
    test_zero_period();
    test_wide_period();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
